// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for the 16-bit CPU.
// It grants a bounded number of clock-enable cycles after a start request.
// The run ends early when the CPU reports a halt.
// Optional single-step mode is enabled by defining CPU_SINGLE_STEP_EN.
// Without the macro, StepMode and Step are ignored.
module cpu_run_ctrl #(
    parameter int CYCLE_W        = 16,
    parameter int DEFAULT_CYCLES = 30
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [CYCLE_W-1:0] CycleCount,
    input  logic               Halt,
    input  logic               StepMode,
    input  logic               Step,
    output logic               CpuEnable,
    output logic               Busy,
    output logic               Done,
    output logic               HaltedEarly,
    output logic [CYCLE_W-1:0] CyclesRun
);

    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_t;

`ifdef CPU_SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    localparam logic [CYCLE_W-1:0] DEF_CYC = CYCLE_W'(DEFAULT_CYCLES);

    state_t             state;
    logic [CYCLE_W-1:0] target;
    logic [CYCLE_W-1:0] cnt_nxt;
    logic               last_cyc;
    logic               step_mode;
    logic               step_go;

    // When the feature is compiled out, these terms are constant 0.
    // That leaves STEP_WAIT unreachable.
    assign step_mode = STEP_EN & StepMode;
    assign step_go   = STEP_EN & Step;
    assign cnt_nxt   = CyclesRun + 1'b1;
    assign last_cyc  = (cnt_nxt == target);

    // Run-control FSM. Every output is a flop updated together with the state.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            target      <= '0;
            CpuEnable   <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            HaltedEarly <= 1'b0;
            CyclesRun   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        target      <= (CycleCount == '0) ? DEF_CYC : CycleCount;
                        CyclesRun   <= '0;
                        HaltedEarly <= 1'b0;
                        Done        <= 1'b0;
                        Busy        <= 1'b1;
                        // In step mode, a run starts parked.
                        // No cycle is granted until the first Step.
                        if (step_mode) begin
                            state     <= STEP_WAIT;
                            CpuEnable <= 1'b0;
                        end else begin
                            state     <= RUN;
                            CpuEnable <= 1'b1;
                        end
                    end
                end
                RUN, STEP_WAIT: begin
                    if (CpuEnable) begin
                        // This edge closes one enabled cycle, so it is counted.
                        CyclesRun <= cnt_nxt;
                        if (last_cyc || Halt) begin
                            // Halt on the final cycle still reports an early halt.
                            HaltedEarly <= Halt;
                            CpuEnable   <= 1'b0;
                            Busy        <= 1'b0;
                            Done        <= 1'b1;
                            state       <= DONE;
                        end else if (step_mode) begin
                            CpuEnable <= 1'b0;
                            state     <= STEP_WAIT;
                        end else begin
                            CpuEnable <= 1'b1;
                            state     <= RUN;
                        end
                    end else if (state == STEP_WAIT) begin
                        if (step_go) begin
                            // Grant exactly one cycle.
                            // The next edge counts it and re-evaluates StepMode.
                            CpuEnable <= 1'b1;
                        end else if (!step_mode) begin
                            // StepMode dropped while parked, so resume free running.
                            CpuEnable <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl.
// Enabled cycles and enable pulses are counted on the falling edge.
// Single-step expectations follow CPU_SINGLE_STEP_EN.
module tb_cpu_run_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] CycleCount = '0;
    logic        Halt = 1'b0;
    logic        StepMode = 1'b0;
    logic        Step = 1'b0;
    logic        CpuEnable, Busy, Done, HaltedEarly;
    logic [15:0] CyclesRun;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int pulses = 0;
    logic prev_en = 1'b0;
    int b_en, b_pu;

    cpu_run_ctrl #(.CYCLE_W(16), .DEFAULT_CYCLES(30)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .CycleCount(CycleCount),
        .Halt(Halt), .StepMode(StepMode), .Step(Step), .CpuEnable(CpuEnable),
        .Busy(Busy), .Done(Done), .HaltedEarly(HaltedEarly), .CyclesRun(CyclesRun)
    );

    always #5 Clock = ~Clock;

    // Count enabled cycles and rising enable pulses mid-cycle.
    always @(negedge Clock) begin
        if (CpuEnable) en_cnt++;
        if (CpuEnable && !prev_en) pulses++;
        prev_en = CpuEnable;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_run(input logic [15:0] cc);
        CycleCount = cc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!Done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, Done}, 32'd1);
    endtask

    initial begin
        // Reset state.
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("rst_en", {31'd0, CpuEnable}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_done", {31'd0, Done}, 0);
        chk("rst_halted", {31'd0, HaltedEarly}, 0);
        chk("rst_cyc", {16'd0, CyclesRun}, 0);

        // Apply Reset mid-run once CyclesRun reaches 7.
        tick();
        start_run(16'd20);
        chk("mid_busy", {31'd0, Busy}, 1);
        begin
            int n = 0;
            while (CyclesRun != 16'd7 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("mid_cyc7", {16'd0, CyclesRun}, 7);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_en", {31'd0, CpuEnable}, 0);
        chk("mid_rst_cyc", {16'd0, CyclesRun}, 0);
        Reset = 1'b0;
        tick();
        chk("mid_busy0", {31'd0, Busy}, 0);
        chk("mid_done0", {31'd0, Done}, 0);

        // CycleCount=0 selects the default run length of 30 cycles.
        b_en = en_cnt;
        start_run(16'd0);
        wait_done("def_done");
        chk("def_en", en_cnt - b_en, 30);
        chk("def_cyc", {16'd0, CyclesRun}, 30);
        chk("def_busy", {31'd0, Busy}, 0);
        chk("def_halted", {31'd0, HaltedEarly}, 0);

        // Halt on the 3rd enabled edge of a 5-cycle run.
        b_en = en_cnt;
        start_run(16'd5);
        tick(); tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        chk("h3_done", {31'd0, Done}, 1);
        chk("h3_cyc", {16'd0, CyclesRun}, 3);
        chk("h3_halted", {31'd0, HaltedEarly}, 1);
        chk("h3_en", en_cnt - b_en, 3);

        // Halt on the final edge of a 4-cycle run, with a Start ignored while Busy.
        b_en = en_cnt;
        start_run(16'd4);
        chk("h4_halted_clr", {31'd0, HaltedEarly}, 0);
        chk("h4_done_clr", {31'd0, Done}, 0);
        tick();
        CycleCount = 16'd2;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        chk("h4_done", {31'd0, Done}, 1);
        chk("h4_cyc", {16'd0, CyclesRun}, 4);
        chk("h4_halted", {31'd0, HaltedEarly}, 1);
        chk("h4_en", en_cnt - b_en, 4);

        // Halt while CpuEnable=0 has no effect in DONE.
        Halt = 1'b1;
        tick(); tick();
        Halt = 1'b0;
        chk("idle_halt_cyc", {16'd0, CyclesRun}, 4);
        chk("idle_halt_en", {31'd0, CpuEnable}, 0);

        // Back-to-back run of one cycle, started from DONE.
        b_en = en_cnt;
        start_run(16'd1);
        chk("b2b_en1", {31'd0, CpuEnable}, 1);
        chk("b2b_done0", {31'd0, Done}, 0);
        chk("b2b_cyc0", {16'd0, CyclesRun}, 0);
        tick();
        chk("b2b_done", {31'd0, Done}, 1);
        chk("b2b_cyc", {16'd0, CyclesRun}, 1);
        chk("b2b_en0", {31'd0, CpuEnable}, 0);
        chk("b2b_cnt", en_cnt - b_en, 1);

        // Single-step stimulus: StepMode set from start, Step pulsed three times.
        b_en = en_cnt;
        b_pu = pulses;
        StepMode = 1'b1;
        start_run(16'd3);
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
            Step = 1'b1;
            tick();
            Step = 1'b0;
            tick();
        end
        StepMode = 1'b0;
        chk("step_done", {31'd0, Done}, 1);
        chk("step_cyc", {16'd0, CyclesRun}, 3);
        chk("step_en", en_cnt - b_en, 3);
`ifdef CPU_SINGLE_STEP_EN
        chk("step_pulses", pulses - b_pu, 3);
`else
        chk("step_pulses", pulses - b_pu, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Hardware run controller for the 16-bit CPU. It produces the clock-enable that lets the CPU advance.
- Grants exactly N enabled cycles after a start request, then stops the CPU. It can also stop early when the CPU reports a halt.
- Replaces the free-running fixed-length clock stimulus, so runs have a bounded, countable length in both synthesis and simulation.

Parameters:
- CYCLE_W, 16, width of the cycle-count input and the cycles-run counter.
- DEFAULT_CYCLES, 30, run length used when CycleCount is 0 at start.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  run request; sampled only in IDLE or DONE.
- CycleCount  input  CYCLE_W  requested run length; sampled with Start.
- Halt  input  1  CPU halt indication; sampled only while CpuEnable=1.
- StepMode  input  1  single-step select (see Optional Feature).
- Step  input  1  single-step advance request (see Optional Feature).
- CpuEnable  output  1  registered clock-enable to the CPU.
- Busy  output  1  high in RUN or STEP_WAIT.
- Done  output  1  high in DONE.
- HaltedEarly  output  1  run ended because of Halt.
- CyclesRun  output  CYCLE_W  number of enabled cycles granted in the current or last run.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-high on Reset.
- Reset state: IDLE, CpuEnable=0, Busy=0, Done=0, HaltedEarly=0, CyclesRun=0, internal target=0.
- Reset asserted mid-run: CpuEnable drops immediately (asynchronously); all outputs return to their reset values.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, RUN, STEP_WAIT, DONE.
- IDLE or DONE, Start=1 at edge k:
  - target <= (CycleCount==0) ? DEFAULT_CYCLES : CycleCount.
  - CyclesRun <= 0, HaltedEarly <= 0, Done <= 0.
  - Go to RUN; CpuEnable=1 from edge k.
- RUN, every edge with CpuEnable=1: CyclesRun <= CyclesRun+1.
  - If CyclesRun+1 == target: CpuEnable <= 0, go to DONE.
  - Else if Halt=1: CpuEnable <= 0, HaltedEarly <= 1, go to DONE. The halting cycle is counted.
  - Else stay in RUN.
  - Result: CpuEnable is high for exactly target consecutive cycles when no Halt occurs.
- Halt and final count on the same edge: go to DONE with HaltedEarly=1.
- Start while Busy: ignored. CycleCount changes while Busy: ignored, because target is latched.
- DONE: Done=1 and Busy=0, held until the next Start. Start in DONE behaves exactly as in IDLE, so back-to-back runs have one idle edge between them.
- Counter width: target ≤ 2^CYCLE_W−1. CyclesRun never wraps because the run ends at target.
- Halt while CpuEnable=0: ignored.

Optional Feature:
- Macro: CPU_SINGLE_STEP_EN.
- Defined, RUN with StepMode=1 at an edge:
  - Go to STEP_WAIT with CpuEnable <= 0. CyclesRun is still updated for that edge if CpuEnable was 1.
- Defined, in STEP_WAIT:
  - Step=1 at an edge sets CpuEnable <= 1 for exactly one cycle. That cycle is counted, with the same target/Halt checks as RUN.
  - After that cycle: back to STEP_WAIT if StepMode=1, otherwise to RUN.
  - Step held high grants one cycle per two edges (enable cycle, then wait cycle).
- Not defined: StepMode and Step are ignored, STEP_WAIT is unreachable, and behaviour is pure RUN.

Test Plan:
- Reset mid-RUN: CyclesRun=7, Reset pulse → CpuEnable=0 immediately; after release all outputs 0 and state IDLE; a new Start works.
- Start=1, CycleCount=0 → CpuEnable high exactly 30 edges; then Done=1, Busy=0, CyclesRun=30, HaltedEarly=0.
- Start, CycleCount=5; Halt=1 on the 3rd enabled edge → CpuEnable high 3 cycles; CyclesRun=3, HaltedEarly=1, Done=1.
- Start, CycleCount=4; Halt=1 on the 4th enabled edge → CyclesRun=4, HaltedEarly=1; second Start with CycleCount=2 while Busy is ignored.
- Back-to-back: from DONE, Start with CycleCount=1 → exactly one CpuEnable cycle; CyclesRun=1, Done=1 on the following edge.
- CPU_SINGLE_STEP_EN defined: CycleCount=3, StepMode=1 from start, Step pulsed 3 times → 3 isolated single-cycle CpuEnable pulses, then DONE with CyclesRun=3. Without the macro, the same stimulus gives 3 contiguous enable cycles.
